// File: rtl/alarm_pkg.sv
// Shared types, widths and helpers for the multi-channel alarm controller.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  // Edit-mode sequence stepped by the mode button.
  typedef enum logic [2:0] {
    IDLE,
    SEL,
    HOUR,
    MIN,
    ONOFF
  } state_t;

  // Width of an alarm index; at least one bit even for a single channel.
  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next edit mode on a mode-button press.
  function automatic state_t next_mode(input state_t s);
    case (s)
      IDLE:    return SEL;
      SEL:     return HOUR;
      HOUR:    return MIN;
      MIN:     return ONOFF;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_control_multi_button_edge.sv
// Rising-edge detector for a debounced button level. The previous-level
// register resets to 1 so a button held through reset produces no event
// until it has been released and pressed again. The event is registered,
// so it is seen by downstream logic one cycle after the rise is sampled.
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_q;

  // Track the previous level and emit a one-cycle pulse on each 0->1 transition.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
      pulse  <= 1'b0;
    end else begin
      prev_q <= level;
      pulse  <= level & ~prev_q;
    end
  end

endmodule

// File: rtl/alarm_control_multi.sv
// Multi-channel alarm controller: two-button editing of NUM_ALARMS alarm
// times with per-alarm enables, minute-tick matching against the running
// clock, and a ring output with dismiss and timeout.
module alarm_control_multi
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int HOUR_MAX     = 23,
  parameter int MIN_MAX      = 59,
  parameter int RING_MINUTES = 2,
  localparam int IDXW        = idxw(NUM_ALARMS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SW_F1,
  input  logic                  SW_F2,
  input  logic [HOUR_W-1:0]     CUR_HOUR,
  input  logic [MIN_W-1:0]      CUR_MIN,
  input  logic                  MIN_TICK,
  output logic [IDXW-1:0]       ALM_SEL,
  output logic                  ALM_HOUR,
  output logic                  ALM_MIN,
  output logic                  ALM_ONOFF,
  output logic [HOUR_W-1:0]     ALM_SET_HOUR,
  output logic [MIN_W-1:0]      ALM_SET_MIN,
  output logic [NUM_ALARMS-1:0] ALM_EN,
  output logic                  ALM_RING,
  output logic [IDXW-1:0]       ALM_RING_ID
);

  localparam int CNT_W = (RING_MINUTES > 0) ? $clog2(RING_MINUTES + 1) : 1;

  state_t                  state_q;
  logic [IDXW-1:0]         sel_q;
  logic [HOUR_W-1:0]       hour_q [NUM_ALARMS];
  logic [MIN_W-1:0]        min_q  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   en_q;
  logic                    ring_q;
  logic [IDXW-1:0]         ring_id_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_inc;

  logic f1_pulse;
  logic f2_pulse;
  logic f1_evt;
  logic f2_evt;
  logic hit;
  logic [IDXW-1:0] hit_idx;

  button_edge u_edge_f1 (
    .clk   (CLK),
    .rst   (RST),
    .level (SW_F1),
    .pulse (f1_pulse)
  );

  button_edge u_edge_f2 (
    .clk   (CLK),
    .rst   (RST),
    .level (SW_F2),
    .pulse (f2_pulse)
  );

  // The mode button wins a simultaneous press; the adjust press is dropped.
  assign f1_evt  = f1_pulse;
  assign f2_evt  = f2_pulse & ~f1_pulse;
  assign cnt_inc = cnt_q + 1'b1;

  // Find the lowest-indexed enabled alarm matching the new minute value.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (MIN_TICK) begin
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
        if (en_q[i] && (hour_q[i] == CUR_HOUR) && (min_q[i] == CUR_MIN)) begin
          hit     = 1'b1;
          hit_idx = IDXW'(i);
        end
      end
    end
  end

  // Edit-mode FSM and alarm storage; adjust presses are swallowed while ringing.
  // NOTE: the alarm register arrays are reset explicitly because a freshly
  // reset controller must hold 00:00 with every alarm disabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hour_q[i] <= '0;
        min_q[i]  <= '0;
      end
    end else if (f1_evt) begin
      state_q <= next_mode(state_q);
    end else if (f2_evt && !ring_q) begin
      case (state_q)
        SEL: begin
          sel_q <= (sel_q == IDXW'(NUM_ALARMS - 1)) ? '0 : sel_q + 1'b1;
        end
        HOUR: begin
          hour_q[sel_q] <= (hour_q[sel_q] == HOUR_W'(HOUR_MAX)) ? '0
                                                                : hour_q[sel_q] + 1'b1;
        end
        MIN: begin
          min_q[sel_q] <= (min_q[sel_q] == MIN_W'(MIN_MAX)) ? '0
                                                            : min_q[sel_q] + 1'b1;
        end
        ONOFF: begin
          en_q[sel_q] <= ~en_q[sel_q];
        end
        default: begin
        end
      endcase
    end
  end

  // Ring control: a match (re)starts the ring, then dismiss or timeout stops it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ring_q    <= 1'b0;
      ring_id_q <= '0;
      cnt_q     <= '0;
    end else if (hit) begin
      ring_q    <= 1'b1;
      ring_id_q <= hit_idx;
      cnt_q     <= '0;
    end else if (ring_q) begin
      if (f2_evt) begin
        ring_q <= 1'b0;
      end else if (MIN_TICK) begin
        cnt_q <= cnt_inc;
        if (cnt_inc >= CNT_W'(RING_MINUTES)) begin
          ring_q <= 1'b0;
        end
      end
    end
  end

  assign ALM_SEL      = sel_q;
  assign ALM_HOUR     = (state_q == HOUR);
  assign ALM_MIN      = (state_q == MIN);
  assign ALM_ONOFF    = (state_q == ONOFF);
  assign ALM_SET_HOUR = hour_q[sel_q];
  assign ALM_SET_MIN  = min_q[sel_q];
  assign ALM_EN       = en_q;
  assign ALM_RING     = ring_q;
  assign ALM_RING_ID  = ring_id_q;

endmodule
